// File: rtl/regread_if.sv
// Handshake bundle between the operand-fetch port, its requester and the execute stage.
// master drives requests and pop acknowledgements; slave is the regread side.
interface regread_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       rsel_a;
  logic [2:0]       rsel_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [2:0]       tag_a;
  logic [2:0]       tag_b;

  modport master (
    output req_valid, rsel_a, rsel_b, out_ready,
    input  req_ready, out_valid, opa, opb, tag_a, tag_b
  );

  modport slave (
    input  req_valid, rsel_a, rsel_b, out_ready,
    output req_ready, out_valid, opa, opb, tag_a, tag_b
  );
endinterface

// File: rtl/regread.sv
// Operand-fetch read port: snapshots two register operands, with write-back
// forwarding, into a 2-entry FIFO that feeds the execute stage.
module regread #(
  parameter int WIDTH   = 16,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  input  logic [WIDTH-1:0] q3,
  input  logic [WIDTH-1:0] q4,
  input  logic [WIDTH-1:0] q5,
  input  logic [WIDTH-1:0] q6,
  input  logic [WIDTH-1:0] q7,
  input  logic             wb_load,
  input  logic [2:0]       wb_sel,
  input  logic [WIDTH-1:0] wb_d,
  regread_if.slave         bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state;
  logic             wp, rp;
  logic             req_ready_r, out_valid_r;
  logic [WIDTH-1:0] ent_a [2];
  logic [WIDTH-1:0] ent_b [2];
  logic [2:0]       ent_ta [2];
  logic [2:0]       ent_tb [2];

  logic [WIDTH-1:0] qv [8];
  logic [WIDTH-1:0] opnd_a, opnd_b;
  logic             push, pop;

  always_comb begin
    qv[0] = q0; qv[1] = q1; qv[2] = q2; qv[3] = q3;
    qv[4] = q4; qv[5] = q5; qv[6] = q6; qv[7] = q7;
  end

  // Later checks win: the zero-register rule overrides forwarding.
  always_comb begin
    opnd_a = qv[bus.rsel_a];
    if (wb_load && (wb_sel == bus.rsel_a)) opnd_a = wb_d;
    if (ZERO_R0 && (bus.rsel_a == 3'd0))   opnd_a = '0;
    opnd_b = qv[bus.rsel_b];
    if (wb_load && (wb_sel == bus.rsel_b)) opnd_b = wb_d;
    if (ZERO_R0 && (bus.rsel_b == 3'd0))   opnd_b = '0;
  end

  assign push = bus.req_valid && req_ready_r;
  assign pop  = out_valid_r && bus.out_ready;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state       <= EMPTY;
      wp          <= 1'b0;
      rp          <= 1'b0;
      req_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        ent_a[i]  <= '0;
        ent_b[i]  <= '0;
        ent_ta[i] <= '0;
        ent_tb[i] <= '0;
      end
    end else begin
      if (push) begin
        ent_a[wp]  <= opnd_a;
        ent_b[wp]  <= opnd_b;
        ent_ta[wp] <= bus.rsel_a;
        ent_tb[wp] <= bus.rsel_b;
        wp         <= ~wp;
      end
      if (pop) rp <= ~rp;

      case (state)
        EMPTY: if (push) begin
          state       <= ONE;
          out_valid_r <= 1'b1;
        end
        ONE: begin
          if (push && !pop) begin
            state       <= FULL;
            req_ready_r <= 1'b0;
          end else if (pop && !push) begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        FULL: if (pop) begin
          state       <= ONE;
          req_ready_r <= 1'b1;
        end
        default: begin
          state       <= EMPTY;
          req_ready_r <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.opa       = ent_a[rp];
  assign bus.opb       = ent_b[rp];
  assign bus.tag_a     = ent_ta[rp];
  assign bus.tag_b     = ent_tb[rp];

endmodule

// File: tb/tb_regread.sv
// Directed bench for regread: vector table for the streaming path plus
// hand-written reset, backpressure/snapshot and zero-register sequences.
module tb_regread;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [15:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic        wb_load;
  logic [2:0]  wb_sel;
  logic [15:0] wb_d;

  regread_if #(.WIDTH(16)) bus  ();
  regread_if #(.WIDTH(16)) bus2 ();

  regread #(.WIDTH(16), .ZERO_R0(1'b0)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .wb_load(wb_load), .wb_sel(wb_sel), .wb_d(wb_d),
    .bus(bus)
  );

  regread #(.WIDTH(16), .ZERO_R0(1'b1)) dut_z (
    .CLK(CLK), .RSTN(RSTN),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .wb_load(wb_load), .wb_sel(wb_sel), .wb_d(wb_d),
    .bus(bus2)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  ra, rb;
    logic        wl;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic [15:0] ea, eb;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string name, input logic [15:0] ea, input logic [15:0] eb,
                          input logic [2:0] ta, input logic [2:0] tb);
    chk({name, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({name, ".opa"},   {16'd0, bus.opa},   {16'd0, ea});
    chk({name, ".opb"},   {16'd0, bus.opb},   {16'd0, eb});
    chk({name, ".tag_a"}, {29'd0, bus.tag_a}, {29'd0, ta});
    chk({name, ".tag_b"}, {29'd0, bus.tag_b}, {29'd0, tb});
  endtask

  initial begin
    q0 = 16'h0F0F; q1 = 16'h0010; q2 = 16'hBEEF; q3 = 16'h1234;
    q4 = 16'h0001; q5 = 16'h0042; q6 = 16'h6666; q7 = 16'h7007;
    wb_load = 1'b0; wb_sel = 3'd0; wb_d = 16'h0000;
    bus.req_valid = 1'b0; bus.rsel_a = 3'd0; bus.rsel_b = 3'd0; bus.out_ready = 1'b1;
    bus2.req_valid = 1'b0; bus2.rsel_a = 3'd0; bus2.rsel_b = 3'd0; bus2.out_ready = 1'b1;

    vecs[0] = '{ra:3'd2, rb:3'd5, wl:1'b0, ws:3'd0, wd:16'h0000, ea:16'hBEEF, eb:16'h0042};
    vecs[1] = '{ra:3'd4, rb:3'd4, wl:1'b1, ws:3'd4, wd:16'hA5A5, ea:16'hA5A5, eb:16'hA5A5};
    vecs[2] = '{ra:3'd7, rb:3'd0, wl:1'b1, ws:3'd0, wd:16'h9999, ea:16'h7007, eb:16'h9999};
    vecs[3] = '{ra:3'd3, rb:3'd6, wl:1'b1, ws:3'd1, wd:16'hDEAD, ea:16'h1234, eb:16'h6666};
    vecs[4] = '{ra:3'd0, rb:3'd0, wl:1'b0, ws:3'd0, wd:16'h0000, ea:16'h0F0F, eb:16'h0F0F};
    vecs[5] = '{ra:3'd6, rb:3'd7, wl:1'b0, ws:3'd6, wd:16'hFFFF, ea:16'h6666, eb:16'h7007};

    // Reset state
    step(); step();
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst.opa", {16'd0, bus.opa}, 32'd0);
    chk("rst.opb", {16'd0, bus.opb}, 32'd0);
    RSTN = 1'b1;

    // Push then reset mid-operation with a request held
    bus.req_valid = 1'b1; bus.rsel_a = 3'd3; bus.rsel_b = 3'd3; bus.out_ready = 1'b0;
    step();
    chk_head("pre_rst", 16'h1234, 16'h1234, 3'd3, 3'd3);
    RSTN = 1'b0;
    step();
    chk("mid_rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst.req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mid_rst.opa", {16'd0, bus.opa}, 32'd0);
    chk("mid_rst.opb", {16'd0, bus.opb}, 32'd0);
    RSTN = 1'b1;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Streaming vectors: one push and one pop per cycle, head is the latest push
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = 1'b1;
      bus.rsel_a = vecs[i].ra; bus.rsel_b = vecs[i].rb;
      wb_load = vecs[i].wl; wb_sel = vecs[i].ws; wb_d = vecs[i].wd;
      step();
      chk_head($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ra, vecs[i].rb);
      chk($sformatf("vec%0d.req_ready", i), {31'd0, bus.req_ready}, 32'd1);
    end
    bus.req_valid = 1'b0; wb_load = 1'b0;
    step();
    chk("drain.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure and snapshot
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b1; bus.rsel_a = 3'd2; bus.rsel_b = 3'd5;
    step();
    chk("bp1.req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk_head("bp1", 16'hBEEF, 16'h0042, 3'd2, 3'd5);
    bus.rsel_a = 3'd1; bus.rsel_b = 3'd6;
    step();
    chk("bp2.req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk_head("bp2", 16'hBEEF, 16'h0042, 3'd2, 3'd5);
    q1 = 16'h0020;
    bus.rsel_a = 3'd1; bus.rsel_b = 3'd5;
    step();
    chk("bp3.req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk_head("bp3", 16'hBEEF, 16'h0042, 3'd2, 3'd5);
    bus.out_ready = 1'b1;
    step();
    chk("bp4.req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk_head("snap", 16'h0010, 16'h6666, 3'd1, 3'd6);
    step();
    chk_head("bp5", 16'h0020, 16'h0042, 3'd1, 3'd5);
    bus.req_valid = 1'b0;
    step();
    chk("bp6.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Zero-register instance: r0 reads 0 despite q0 and a forward to r0
    q0 = 16'hFFFF; wb_load = 1'b1; wb_sel = 3'd0; wb_d = 16'h7777;
    bus2.req_valid = 1'b1; bus2.rsel_a = 3'd0; bus2.rsel_b = 3'd3;
    step();
    bus2.req_valid = 1'b0; wb_load = 1'b0;
    chk("z.out_valid", {31'd0, bus2.out_valid}, 32'd1);
    chk("z.opa", {16'd0, bus2.opa}, 32'd0);
    chk("z.opb", {16'd0, bus2.opb}, 32'h1234);
    step();
    chk("z.drain", {31'd0, bus2.out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regread.md
# regread

Operand-fetch read port for the 8×16-bit CPU register file. It accepts read requests for two source registers through a valid/ready handshake and snapshots both operands from the register-file outputs. A write being committed in the same cycle is forwarded, so the read always returns the post-write value. Results sit in a 2-entry FIFO that feeds the execute stage with its own valid/ready handshake.

## Interface
Parameters
- WIDTH, 16: register and operand width.
- ZERO_R0, 0: when 1, any read of register 0 returns 0, ignoring q0 and forwarding.

Ports
- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- q0 … q7  in  WIDTH each  current register-file contents.
- wb_load  in  1  register-file write enable this cycle.
- wb_sel  in  3  register-file write index this cycle.
- wb_d  in  WIDTH  register-file write data this cycle.
- req_valid  in  1  read request present.
- req_ready  out  1  request can be accepted.
- rsel_a  in  3  source index A.
- rsel_b  in  3  source index B.
- out_valid  out  1  head FIFO entry valid.
- out_ready  in  1  consumer takes the head entry.
- opa  out  WIDTH  head entry, operand A.
- opb  out  WIDTH  head entry, operand B.
- tag_a  out  3  head entry, index A.
- tag_b  out  3  head entry, index B.

## Operation
- Push: req_valid && req_ready at a rising edge.
- Pop: out_valid && out_ready at a rising edge.
- Operand select for each of A and B, in priority order at the push cycle:
  - ZERO_R0 && rsel==0 → 0.
  - wb_load && wb_sel==rsel → wb_d (forward).
  - otherwise → q[rsel].
- Each entry stores {operand A, operand B, rsel_a, rsel_b}.
- Entries are snapshots. A later write to a register already captured does not change a stored entry.
- FIFO: depth 2, write pointer wp, read pointer rp (1 bit each, wrapping 1→0), occupancy count 0..2.
- States by count: EMPTY (0), ONE (1), FULL (2).
  - Push only: count+1, wp toggles.
  - Pop only: count−1, rp toggles.
  - Push and pop together: count unchanged, both pointers toggle. Legal only in ONE.
- req_ready = (count != 2). It is registered-state derived and has no combinational path from out_ready.
- FULL with a pop in the same cycle: no push that cycle. req_ready stays 0; throughput loss is accepted.
- EMPTY: out_valid = 0. out_ready is ignored. opa, opb, tag_a and tag_b are don't-care. Bench compares them only when out_valid = 1.
- out_valid = (count != 0). opa, opb, tag_a and tag_b are driven from entry[rp].

## Timing
- Reset (RSTN low at a rising edge), which overrides push and pop:
  - count = 0, wp = 0, rp = 0, all entry storage = 0.
  - Outputs: out_valid = 0, req_ready = 1, opa = 0, opb = 0, tag_a = 0, tag_b = 0.
- Reset mid-operation discards all stored entries. Requests presented in the reset cycle are not accepted.
- Latency: a request pushed at edge k is visible with out_valid = 1 after edge k, if the FIFO was empty.
- Throughput: one push and one pop per cycle in steady state, while count stays at 1.
- Forwarding: a wb_load at the push edge is reflected in the captured operand. The register file itself updates at that same edge.
- Reading the same register on both A and B is legal; both operands get identical values.
- Handshake rule: req_valid and its fields must stay stable while req_ready = 0. out_valid and the head fields stay stable until popped.

## Test plan
- Reset: preload q3 = 0x1234. Push a request, then assert RSTN = 0 for one cycle → out_valid = 0, req_ready = 1, opa = opb = 0.
- Basic read: q2 = 0xBEEF, q5 = 0x0042. Push rsel_a = 2, rsel_b = 5 → next cycle out_valid = 1, opa = 0xBEEF, opb = 0x0042, tag_a = 2, tag_b = 5.
- Forward: q4 = 0x0001 with wb_load = 1, wb_sel = 4, wb_d = 0xA5A5 in the push cycle for rsel_a = rsel_b = 4 → opa = opb = 0xA5A5.
- Backpressure: out_ready = 0, push 3 requests with req_valid held → only 2 accepted, req_ready = 0 after the second. Set out_ready = 1 → outputs appear in order, then the third request is accepted.
- Snapshot: push rsel_a = 1 (q1 = 0x0010) while stalled, then write q1 = 0x0020 → popped opa = 0x0010.
- ZERO_R0 = 1: q0 = 0xFFFF and wb_load to register 0 with wb_d = 0x7777, push rsel_a = 0 → opa = 0x0000.
